// File: rtl/instr_queue.sv
// Circular instruction FIFO between fetch and dispatch; each entry carries its PC.
// Optional combinational empty-queue bypass is enabled by defining IQ_BYPASS_EN.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     iq_valid,
  input  logic [XLEN-1:0]          instruction,
  input  logic [XLEN-1:0]          pc_in,
  output logic                     iq_ready,
  input  logic                     flush_in,
  input  logic                     dispatch_ready_in,
  output logic                     inst_valid_out,
  output logic [XLEN-1:0]          inst_out,
  output logic [XLEN-1:0]          pc_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] P_ONE = AW'(1);

  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [AW:0]     r_count;
  logic [XLEN-1:0] r_inst_mem [DEPTH];
  logic [XLEN-1:0] r_pc_mem   [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_enq;
  logic w_deq;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL);
  assign w_deq     = !w_empty && dispatch_ready_in;
  assign iq_ready  = !w_full;
  assign count_out = r_count;

`ifdef IQ_BYPASS_EN
  logic w_bypass;
  assign w_bypass       = w_empty && iq_valid && !flush_in;
  assign inst_valid_out = !w_empty || w_bypass;
  // A bypassed instruction taken by dispatch the same cycle never touches storage.
  assign w_enq          = iq_valid && !w_full && !(w_bypass && dispatch_ready_in);

  always_comb begin
    inst_out = '0;
    pc_out   = '0;
    if (!w_empty) begin
      inst_out = r_inst_mem[r_head];
      pc_out   = r_pc_mem[r_head];
    end else if (w_bypass) begin
      inst_out = instruction;
      pc_out   = pc_in;
    end
  end
`else
  assign inst_valid_out = !w_empty;
  assign w_enq          = iq_valid && !w_full;

  always_comb begin
    inst_out = '0;
    pc_out   = '0;
    if (!w_empty) begin
      inst_out = r_inst_mem[r_head];
      pc_out   = r_pc_mem[r_head];
    end
  end
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + P_ONE;
      if (w_deq) r_head <= r_head + P_ONE;
      if (w_enq && !w_deq)      r_count <= r_count + C_ONE;
      else if (!w_enq && w_deq) r_count <= r_count - C_ONE;
    end
  end

  // Storage is deliberately unreset; outputs are masked while empty.
  always_ff @(posedge clk_in) begin
    if (w_enq && !flush_in) begin
      r_inst_mem[r_tail] <= instruction;
      r_pc_mem[r_tail]   <= pc_in;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: a reference model pushes accepted entries,
// a negedge monitor compares head/valid/ready/count against it.
module tb_instr_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
`ifdef IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic            iq_valid;
  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] pc_in;
  logic            iq_ready;
  logic            flush_in;
  logic            dispatch_ready_in;
  logic            inst_valid_out;
  logic [XLEN-1:0] inst_out;
  logic [XLEN-1:0] pc_out;
  logic [$clog2(DEPTH):0] count_out;

  instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .iq_valid          (iq_valid),
    .instruction       (instruction),
    .pc_in             (pc_in),
    .iq_ready          (iq_ready),
    .flush_in          (flush_in),
    .dispatch_ready_in (dispatch_ready_in),
    .inst_valid_out    (inst_valid_out),
    .inst_out          (inst_out),
    .pc_out            (pc_out),
    .count_out         (count_out)
  );

  always #5 clk_in = ~clk_in;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: expected queue contents and occupancy.
  logic [63:0] sb[$];
  int  m_count;
  logic m_show, m_take, m_deq, m_enq;
  assign m_show = BYP && (m_count == 0) && iq_valid && !flush_in;
  assign m_take = m_show && dispatch_ready_in;
  assign m_deq  = (m_count != 0) && dispatch_ready_in;
  assign m_enq  = iq_valid && (m_count != DEPTH) && !m_take;

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sb.delete();
      m_count <= 0;
    end else if (flush_in) begin
      sb.delete();
      m_count <= 0;
    end else begin
      if (m_enq) sb.push_back({instruction, pc_in});
      m_count <= m_count + int'(m_enq) - int'(m_deq);
    end
  end

  // Monitor: compares DUT head against scoreboard; pops on each real dequeue.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk_in);
      if (rst_n_in) begin
        chk("mon_valid", {31'b0, inst_valid_out}, {31'b0, (m_count != 0) || m_show});
        chk("mon_ready", {31'b0, iq_ready}, {31'b0, m_count != DEPTH});
        chk("mon_count", 32'(count_out), 32'(m_count));
        if (inst_valid_out) begin
          if (m_show) begin
            exp = {instruction, pc_in};
          end else if (sb.size() == 0) begin
            exp = '0;
            n_total++;
            $display("FAIL mon_underflow: got valid head expected empty at %0t", $time);
          end else begin
            exp = sb[0];
          end
          chk("mon_inst", inst_out, exp[63:32]);
          chk("mon_pc", pc_out, exp[31:0]);
          if (dispatch_ready_in && !flush_in && !m_show && sb.size() != 0)
            void'(sb.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    iq_valid          = v;
    instruction       = ins;
    pc_in             = pc;
    dispatch_ready_in = rdy;
    flush_in          = fl;
    @(posedge clk_in);
    #1;
    iq_valid          = 1'b0;
    dispatch_ready_in = 1'b0;
    flush_in          = 1'b0;
  endtask

  function automatic logic [31:0] mk_ins(input int k);
    return 32'h0000_0013 | (32'(k) << 20);
  endfunction

  initial begin
    rst_n_in = 1'b0;
    iq_valid = 1'b0;
    instruction = '0;
    pc_in = '0;
    flush_in = 1'b0;
    dispatch_ready_in = 1'b0;
    #12;
    chk("rst_valid", {31'b0, inst_valid_out}, 32'd0);
    chk("rst_ready", {31'b0, iq_ready}, 32'd1);
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_inst",  inst_out, 32'd0);
    chk("rst_pc",    pc_out, 32'd0);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Single enqueue: visible one edge later.
    drive(1'b1, 32'h0015_8593, 32'h0, 1'b0, 1'b0);
    chk("t1_valid", {31'b0, inst_valid_out}, 32'd1);
    chk("t1_inst",  inst_out, 32'h0015_8593);
    chk("t1_pc",    pc_out, 32'h0);
    chk("t1_count", 32'(count_out), 32'd1);

    // Two entries, then dispatch them in order.
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b1, 32'h0015_8593, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h0026_0613, 32'h4, 1'b0, 1'b0);
    chk("t2_head0", inst_out, 32'h0015_8593);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t2_head1", inst_out, 32'h0026_0613);
    chk("t2_pc1",   pc_out, 32'h4);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t2_valid", {31'b0, inst_valid_out}, 32'd0);
    chk("t2_count", 32'(count_out), 32'd0);

    // Fill to full; ninth held until a slot frees.
    for (int k = 0; k < 8; k++) drive(1'b1, mk_ins(k), 32'(4*k), 1'b0, 1'b0);
    chk("t3_count", 32'(count_out), 32'd8);
    chk("t3_ready", {31'b0, iq_ready}, 32'd0);
    drive(1'b1, mk_ins(8), 32'h20, 1'b0, 1'b0);
    chk("t3_hold",  32'(count_out), 32'd8);
    drive(1'b1, mk_ins(8), 32'h20, 1'b1, 1'b0);
    chk("t3_nofill", 32'(count_out), 32'd7);
    chk("t3_head",  pc_out, 32'h4);
    drive(1'b1, mk_ins(8), 32'h20, 1'b0, 1'b0);
    chk("t3_refill", 32'(count_out), 32'd8);
    for (int k = 0; k < 8; k++) drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t3_drained", 32'(count_out), 32'd0);

    // Streaming at occupancy 3 across pointer wrap.
    for (int k = 0; k < 3; k++) drive(1'b1, mk_ins(100 + k), 32'h1000 + 32'(4*k), 1'b0, 1'b0);
    for (int k = 3; k < 23; k++) begin
      drive(1'b1, mk_ins(100 + k), 32'h1000 + 32'(4*k), 1'b1, 1'b0);
      chk("t4_count", 32'(count_out), 32'd3);
    end
    chk("t4_head", pc_out, 32'h1000 + 32'(4*20));
    for (int k = 0; k < 3; k++) drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t4_drained", 32'(count_out), 32'd0);

    // Flush wins over a simultaneous enqueue.
    for (int k = 0; k < 5; k++) drive(1'b1, mk_ins(200 + k), 32'h2000 + 32'(4*k), 1'b0, 1'b0);
    chk("t5_pre", 32'(count_out), 32'd5);
    drive(1'b1, 32'h0036_8693, 32'h3000, 1'b1, 1'b1);
    chk("t5_count", 32'(count_out), 32'd0);
    chk("t5_valid", {31'b0, inst_valid_out}, 32'd0);
    for (int k = 0; k < 3; k++) drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t5_after", {31'b0, inst_valid_out}, 32'd0);

    // Asynchronous reset mid-cycle.
    for (int k = 0; k < 4; k++) drive(1'b1, mk_ins(300 + k), 32'h4000 + 32'(4*k), 1'b0, 1'b0);
    chk("t6_pre", 32'(count_out), 32'd4);
    #2 rst_n_in = 1'b0;
    #1;
    chk("t6_valid", {31'b0, inst_valid_out}, 32'd0);
    chk("t6_ready", {31'b0, iq_ready}, 32'd1);
    chk("t6_count", 32'(count_out), 32'd0);
    #1 rst_n_in = 1'b1;
    @(posedge clk_in); #1;

`ifdef IQ_BYPASS_EN
    iq_valid = 1'b1; instruction = 32'h0047_0713; pc_in = 32'h5000; dispatch_ready_in = 1'b1;
    #1;
    chk("t7_byp_valid", {31'b0, inst_valid_out}, 32'd1);
    chk("t7_byp_inst",  inst_out, 32'h0047_0713);
    chk("t7_byp_pc",    pc_out, 32'h5000);
    @(posedge clk_in); #1;
    iq_valid = 1'b0; dispatch_ready_in = 1'b0;
    chk("t7_byp_count", 32'(count_out), 32'd0);
`else
    iq_valid = 1'b1; instruction = 32'h0047_0713; pc_in = 32'h5000; dispatch_ready_in = 1'b1;
    #1;
    chk("t7_nobyp_valid", {31'b0, inst_valid_out}, 32'd0);
    @(posedge clk_in); #1;
    iq_valid = 1'b0; dispatch_ready_in = 1'b0;
    chk("t7_nobyp_count", 32'(count_out), 32'd1);
    chk("t7_nobyp_inst",  inst_out, 32'h0047_0713);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
`endif
    chk("final_count", 32'(count_out), 32'd0);
    repeat (2) @(posedge clk_in);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Circular FIFO of fetched RV32I instructions, one entry per instruction, each tagged with its PC.
- Sits between fetch (producer, which drives iq_valid/instruction) and dispatch into the reservation stations (consumer, which feeds the CDB path).
- Absorbs dispatch stalls and supports a full flush on branch redirect.

Parameters:
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- XLEN, 32, width of instruction and PC.

Ports:
- clk_in  input  1  system clock; all state changes on the rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- iq_valid  input  1  fetch presents a valid instruction this cycle.
- instruction  input  XLEN  instruction word from fetch.
- pc_in  input  XLEN  PC of the presented instruction.
- iq_ready  output  1  queue can accept; equals not full.
- flush_in  input  1  discard all entries (branch mispredict / redirect).
- dispatch_ready_in  input  1  dispatch can take the head entry this cycle.
- inst_valid_out  output  1  head entry is valid.
- inst_out  output  XLEN  instruction at head.
- pc_out  output  XLEN  PC at head.
- count_out  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - head, tail and count clear to 0.
  - iq_ready=1, inst_valid_out=0, count_out=0.
  - inst_out/pc_out read 0; storage is not cleared and is never visible while empty.
- Enqueue: on a rising edge with iq_valid && iq_ready.
  - Writes {instruction, pc_in} at tail; tail increments modulo DEPTH.
- Dequeue: on a rising edge with inst_valid_out && dispatch_ready_in.
  - head increments modulo DEPTH.
- Outputs:
  - inst_out/pc_out are read from storage[head]; combinational from registered state only.
  - inst_valid_out = (count != 0).
  - iq_ready = (count != DEPTH).
- Latency: an entry enqueued at edge N appears on the outputs after edge N. There is no same-cycle pass-through (except under the optional feature).
- Simultaneous enqueue and dequeue: both happen and count is unchanged. Legal at any non-full, non-empty occupancy.
- Full:
  - iq_ready=0, so any instruction presented is not accepted, even if a dequeue occurs that cycle.
  - Fetch must hold the instruction until iq_ready is high.
  - No overwrite is ever permitted.
- Empty:
  - inst_valid_out=0; dispatch_ready_in is ignored and head does not move.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are determined by count, never by pointer compare.
- Flush:
  - flush_in high at an edge sets head=tail=0 and count=0.
  - Flush has priority over both enqueue and dequeue that cycle; the presented instruction is dropped.
  - Outputs show empty after the edge.
- Reset mid-operation: asynchronous. Outputs go to reset values immediately, without waiting for a clock edge.
- Invariants the bench must check:
  - count_out equals enqueues minus dequeues since the last flush/reset.
  - Dequeue order equals enqueue order.
  - Each PC stays paired with its own instruction.

Optional Feature:
- Macro: IQ_BYPASS_EN.
- Defined:
  - When count==0 and iq_valid is high, inst_valid_out=1 and inst_out/pc_out are driven combinationally from instruction/pc_in.
  - If dispatch_ready_in is also high (and flush_in is low), the instruction is consumed that cycle, is not written, and count stays 0.
  - If dispatch_ready_in is low, the instruction is enqueued normally.
  - Flush still blocks the bypass: with flush_in high, inst_valid_out=0.
- Undefined:
  - Strict one-cycle latency as described above; there is no combinational input-to-output path.

Test Plan:
- Reset, then iq_valid=1 with instruction=0x00158593, pc_in=0x0 for one cycle, dispatch_ready_in=0 -> after the edge, inst_valid_out=1, inst_out=0x00158593, pc_out=0x0, count_out=1.
- Enqueue 0x00158593 (pc 0x0) then 0x00260613 (pc 0x4), then raise dispatch_ready_in -> the outputs present 0x00158593 then 0x00260613 on consecutive cycles, then inst_valid_out=0 and count_out=0.
- Present 9 instructions with pc 0x0..0x20 and dispatch_ready_in=0 -> iq_ready=0 after the 8th; count_out=8; the 9th is held until a dequeue frees a slot and is then accepted; dequeued PCs are 0x0..0x20 in order.
- Stream 20 instructions with iq_valid and dispatch_ready_in both high every cycle from count 3 -> count_out stays 3; pointers wrap past DEPTH; order preserved.
- With count 5, assert flush_in together with iq_valid (instruction 0x00368693) -> after the edge count_out=0, inst_valid_out=0, and 0x00368693 is never dispatched.
- With count 4, pulse rst_n_in low mid-cycle -> inst_valid_out=0, iq_ready=1 and count_out=0 before the next edge.
- With IQ_BYPASS_EN defined, empty queue, iq_valid=1 with instruction=0x00470713 and dispatch_ready_in=1 -> inst_out=0x00470713 in the same cycle, and count_out remains 0 after the edge.
